// File: rtl/router_pkt_source.sv
// Host-side packet generator for the 1x3 router input port: buffers a payload, then
// streams header/payload/parity without gaps, honours busy and reports router err per packet.
module router_pkt_source #(
  parameter int LEN_W      = 6,
  parameter int ERR_WAIT   = 3,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             pl_valid,
  input  logic [7:0]       pl_data,
  output logic             pl_ready,
  input  logic             busy,
  input  logic             err,
  output logic             pkt_valid,
  output logic [7:0]       data_out,
  output logic             tx_done,
  output logic [1:0]       tx_status,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD, HEADER, PAYLOAD, PARITY, WAIT_ERR, GAP
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [7:0]       WAIT_END = 8'(ERR_WAIT - 1);
  localparam logic [7:0]       GAP_END  = 8'(GAP_CYCLES - 1);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] wr_ptr;
  logic [LEN_W-1:0] rd_ptr;
  logic [7:0]       hdr;
  logic [7:0]       parity;
  logic [7:0]       wcnt;
  logic [7:0]       gcnt;
  logic             capture;
  logic [7:0]       mem [2**LEN_W];

  // Header byte is {len, addr} packed into the router's 8-bit data lane.
  function automatic logic [7:0] make_hdr(input logic [LEN_W-1:0] len, input logic [1:0] addr);
    logic [LEN_W+7:0] t;
    t = {6'b0, len, addr};
    return t[7:0];
  endfunction

  always_ff @(posedge clk) begin
    if (state == LOAD && pl_valid) mem[wr_ptr] <= pl_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      pl_ready  <= 1'b0;
      pkt_valid <= 1'b0;
      data_out  <= 8'h00;
      tx_done   <= 1'b0;
      tx_status <= 2'b00;
      pkt_count <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wcnt      <= '0;
      gcnt      <= '0;
      capture   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            len_q     <= cmd_len;
            hdr       <= make_hdr(cmd_len, cmd_addr);
            parity    <= make_hdr(cmd_len, cmd_addr);
            cmd_ready <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            if (cmd_addr == 2'd3) begin
              tx_done   <= 1'b1;
              tx_status <= 2'b10;
              gcnt      <= '0;
              state     <= GAP;
            end else if (cmd_len == '0) begin
              data_out  <= make_hdr(cmd_len, cmd_addr);
              pkt_valid <= 1'b1;
              state     <= HEADER;
            end else begin
              pl_ready <= 1'b1;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (pl_valid) begin
            parity <= parity ^ pl_data;
            wr_ptr <= wr_ptr + LEN_ONE;
            if (wr_ptr == len_q - LEN_ONE) begin
              pl_ready  <= 1'b0;
              data_out  <= hdr;
              pkt_valid <= 1'b1;
              state     <= HEADER;
            end
          end
        end
        HEADER: begin
          if (!busy) begin
            if (len_q != '0) begin
              data_out <= mem[0];
              rd_ptr   <= LEN_ONE;
              state    <= PAYLOAD;
            end else begin
              data_out  <= parity;
              pkt_valid <= 1'b0;
              state     <= PARITY;
            end
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            if (rd_ptr == len_q) begin
              data_out  <= parity;
              pkt_valid <= 1'b0;
              state     <= PARITY;
            end else begin
              data_out <= mem[rd_ptr];
              rd_ptr   <= rd_ptr + LEN_ONE;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            capture <= 1'b0;
            wcnt    <= '0;
            state   <= WAIT_ERR;
          end
        end
        WAIT_ERR: begin
          // data_out keeps the parity byte so the router can re-sample it
          capture <= capture | err;
          wcnt    <= wcnt + 8'd1;
          if (wcnt == WAIT_END) begin
            tx_done   <= 1'b1;
            tx_status <= {1'b0, capture | err};
            pkt_count <= pkt_count + 1'b1;
            gcnt      <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          gcnt <= gcnt + 8'd1;
          if (gcnt == GAP_END) begin
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          pl_ready  <= 1'b0;
          pkt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
